// File: rtl/spi_slave32.sv
// rtl/spi_slave32.sv - SPI mode-0 target: oversampled pins, 32-bit receive word, 1-4 byte preloaded response
module spi_slave32 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe,
    input  logic [31:0] tx_data,
    input  logic [1:0]  tx_nbytes,
    input  logic        tx_load,
    output logic [31:0] dout,
    output logic [2:0]  rx_nbytes,
    output logic        rx_valid,
    output logic        rx_ovf,
    output logic        frame_err,
    output logic        busy
);
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
    logic                   sclk_prev, cs_prev;
    logic [7:0]             settle;
    logic [31:0]            tx_shift, rx_shift, tx_next;
    logic [2:0]             bit_cnt, byte_cnt;
    logic                   ovf;

    wire sclk_s     = sclk_sync[SYNC_STAGES-1];
    wire cs_s       = cs_sync[SYNC_STAGES-1];
    wire sdi_s      = sdi_sync[SYNC_STAGES-1];
    wire sclk_rise  = sclk_s & ~sclk_prev;
    wire sclk_fall  = ~sclk_s & sclk_prev;
    wire cs_fall    = ~cs_s & cs_prev;
    wire cs_rise    = cs_s & ~cs_prev;

    // Response is left-aligned so the MSB of the top valid byte leaves first.
    function automatic logic [31:0] align(input logic [31:0] d, input logic [1:0] n);
        case (n)
            2'd0:    return {d[7:0], 24'h0};
            2'd1:    return {d[15:0], 16'h0};
            2'd2:    return {d[23:0], 8'h0};
            default: return d;
        endcase
    endfunction

    always_comb begin
        tx_next = tx_shift;
        if (tx_load) tx_next = align(tx_data, tx_nbytes);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sdi_sync  <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            settle    <= '0;
            state     <= WAIT_IDLE;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            ovf       <= 1'b0;
            sdo       <= 1'b0;
            sdo_oe    <= 1'b0;
            dout      <= '0;
            rx_nbytes <= '0;
            rx_valid  <= 1'b0;
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            rx_valid  <= 1'b0;
            case (state)
                WAIT_IDLE: begin
                    // The chains reset to idle levels; let them flush before trusting cs.
                    if (settle != 8'(SYNC_STAGES)) begin
                        settle <= settle + 8'd1;
                    end else if (cs_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    tx_shift <= tx_next;
                    if (cs_fall) begin
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        rx_shift <= '0;
                        ovf      <= 1'b0;
                        sdo      <= tx_next[31];
                        sdo_oe   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= DONE;
                    end else begin
                        if (sclk_rise) begin
                            // rx_shift freezes once four bytes are complete.
                            if (byte_cnt != 3'd4) rx_shift <= {rx_shift[30:0], sdi_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (byte_cnt == 3'd4) ovf <= 1'b1;
                                else                  byte_cnt <= byte_cnt + 3'd1;
                            end
                        end
                        if (sclk_fall) begin
                            tx_shift <= {tx_shift[30:0], 1'b0};
                            sdo      <= tx_shift[30];
                        end
                    end
                end
                DONE: begin
                    rx_valid  <= 1'b1;
                    dout      <= (byte_cnt == 3'd4) ? rx_shift : (rx_shift >> bit_cnt);
                    rx_nbytes <= byte_cnt;
                    rx_ovf    <= ovf;
                    frame_err <= (bit_cnt != 3'd0) && !ovf;
                    sdo_oe    <= 1'b0;
                    sdo       <= 1'b0;
                    tx_shift  <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end
endmodule
